// File: rtl/break_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : break_ctrl
// Purpose  : ID-stage interrupt/exception take logic, break-PC write and eret.
//            Optional macro BREAK_CAUSE_EN adds the registered break_cause port.
// Revision : 1.0 - initial release
// ============================================================================
module break_ctrl #(
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  input  logic        id_valid,
  input  logic        id_squash,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] id_pc,
  input  logic        id_undef,
  input  logic        id_syscall,
  input  logic        id_eret,
  input  logic        pipe_stall,
  output logic        break_wr_en,
  output logic [31:0] break_pc,
  output logic        take_vector,
  output logic [31:0] vector_addr,
  output logic        take_return,
  output logic        flush_if,
  output logic        flush_id,
  output logic        kernel_mode
`ifdef BREAK_CAUSE_EN
  ,
  output logic [1:0]  break_cause
`endif
);

  localparam logic [0:0] S_USER   = 1'b0;
  localparam logic [0:0] S_KERNEL = 1'b1;

  localparam logic [1:0] C_CAUSE_NONE  = 2'b00;
  localparam logic [1:0] C_CAUSE_IRQ   = 2'b01;
  localparam logic [1:0] C_CAUSE_UNDEF = 2'b10;
  localparam logic [1:0] C_CAUSE_SYS   = 2'b11;

  logic [0:0] state_q;
  logic [0:0] state_d;
  logic       irq_pending_q;
  logic       irq_pending_d;

  logic       w_user;
  logic       w_id_real;
  logic       w_irq_now;
  logic       w_irq_req;
  logic       w_can_act;
  logic       w_take_undef;
  logic       w_take_sys;
  logic       w_take_irq;
  logic       w_take;
  logic       w_return;

  // Take decision; a stalled or resetting cycle decides nothing.
  always_comb begin
    w_user       = (state_q == S_USER);
    w_id_real    = id_valid & ~id_squash;
    w_irq_now    = irq & w_user;
    w_irq_req    = irq_pending_q | w_irq_now;
    w_can_act    = ~reset & ~pipe_stall;
    w_take_undef = w_can_act & w_user & w_id_real & id_undef;
    w_take_sys   = w_can_act & w_user & w_id_real & id_syscall & ~id_undef;
    // A bubble has no PC to return to, so the interrupt waits in irq_pending.
    w_take_irq   = w_can_act & w_user & w_irq_req & (w_id_real | id_squash)
                   & ~(w_id_real & (id_undef | id_syscall));
    w_take       = w_take_undef | w_take_sys | w_take_irq;
    w_return     = w_can_act & ~w_user & w_id_real & id_eret;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_USER;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_USER:   if (w_take)   state_d = S_KERNEL;
      S_KERNEL: if (w_return) state_d = S_USER;
      default:  state_d = S_USER;
    endcase
  end

  // FSM: outputs
  always_comb begin
    break_wr_en = 1'b0;
    take_vector = 1'b0;
    take_return = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    vector_addr = EXC_VECTOR;
    break_pc    = id_pc;
    kernel_mode = (state_q == S_KERNEL);
    if (w_take) begin
      break_wr_en = 1'b1;
      take_vector = 1'b1;
      flush_if    = 1'b1;
      flush_id    = 1'b1;
      if (w_take_irq) begin
        vector_addr = IRQ_VECTOR;
        break_pc    = id_squash ? redirect_pc : id_pc;
      end else begin
        break_pc    = id_pc + 32'd4;
      end
    end else if (w_return) begin
      take_return = 1'b1;
      flush_if    = 1'b1;
    end
  end

  // Pending interrupt survives stalls, bubbles and kernel residency.
  always_comb begin
    irq_pending_d = irq_pending_q;
    if (w_take_irq) begin
      irq_pending_d = 1'b0;
    end else if (w_irq_now) begin
      irq_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_pending_q <= 1'b0;
    end else begin
      irq_pending_q <= irq_pending_d;
    end
  end

`ifdef BREAK_CAUSE_EN
  logic [1:0] cause_q;
  logic [1:0] cause_d;

  always_comb begin
    cause_d = cause_q;
    if (w_take_undef) begin
      cause_d = C_CAUSE_UNDEF;
    end else if (w_take_sys) begin
      cause_d = C_CAUSE_SYS;
    end else if (w_take_irq) begin
      cause_d = C_CAUSE_IRQ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cause_q <= C_CAUSE_NONE;
    end else begin
      cause_q <= cause_d;
    end
  end

  assign break_cause = cause_q;
`else
  logic w_unused_cause;
  assign w_unused_cause = ^{C_CAUSE_NONE, C_CAUSE_IRQ, C_CAUSE_UNDEF, C_CAUSE_SYS};
`endif

endmodule
`default_nettype wire

// File: tb/tb_break_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_break_ctrl
// Purpose  : Directed test-plan steps plus random traffic against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_break_ctrl;

  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset, irq, id_valid, id_squash, id_undef, id_syscall, id_eret, pipe_stall;
  logic [31:0] redirect_pc, id_pc;
  logic        break_wr_en, take_vector, take_return, flush_if, flush_id, kernel_mode;
  logic [31:0] break_pc, vector_addr;
`ifdef BREAK_CAUSE_EN
  logic [1:0]  break_cause;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Architectural model state
  bit       m_kernel;
  bit       m_pend;
  bit [1:0] m_cause;

  always #5 clk = ~clk;

  break_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .irq         (irq),
    .id_valid    (id_valid),
    .id_squash   (id_squash),
    .redirect_pc (redirect_pc),
    .id_pc       (id_pc),
    .id_undef    (id_undef),
    .id_syscall  (id_syscall),
    .id_eret     (id_eret),
    .pipe_stall  (pipe_stall),
    .break_wr_en (break_wr_en),
    .break_pc    (break_pc),
    .take_vector (take_vector),
    .vector_addr (vector_addr),
    .take_return (take_return),
    .flush_if    (flush_if),
    .flush_id    (flush_id),
    .kernel_mode (kernel_mode)
`ifdef BREAK_CAUSE_EN
    ,
    .break_cause (break_cause)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; irq = 0; id_valid = 0; id_squash = 0; id_undef = 0;
    id_syscall = 0; id_eret = 0; pipe_stall = 0; redirect_pc = 0; id_pc = 0;
  endtask

  // One clock: predict from current inputs, check strobes mid-cycle, advance model.
  task automatic apply();
    int          kind;   // 0 none, 1 irq, 2 undef, 3 syscall
    bit          ret, user, id_real, want_irq;
    logic [31:0] exp_pc, exp_vec;
    logic [4:0]  exp_strobe;
    user     = !m_kernel;
    id_real  = id_valid && !id_squash;
    want_irq = m_pend || (irq && user);
    kind = 0;
    ret  = 0;
    if (!reset && !pipe_stall) begin
      if (user) begin
        if (id_real && id_undef)                      kind = 2;
        else if (id_real && id_syscall)               kind = 3;
        else if (want_irq && (id_real || id_squash))  kind = 1;
      end else if (id_real && id_eret) begin
        ret = 1;
      end
    end
    exp_vec    = (kind == 1) ? IRQ_VECTOR : EXC_VECTOR;
    exp_pc     = (kind >= 2) ? id_pc + 32'd4 : ((kind == 1 && id_squash) ? redirect_pc : id_pc);
    exp_strobe = (kind != 0) ? 5'b11110 : (ret ? 5'b00101 : 5'b00000);
    @(negedge clk);
    check("strobes{wr,vec,fif,fid,ret}",
          {27'd0, break_wr_en, take_vector, flush_if, flush_id, take_return},
          {27'd0, exp_strobe});
    if (kind != 0) begin
      check("break_pc", break_pc, exp_pc);
      check("vector_addr", vector_addr, exp_vec);
    end
    @(posedge clk);
    if (reset) begin
      m_kernel = 0; m_pend = 0; m_cause = 0;
    end else begin
      if (kind != 0) begin
        m_kernel = 1;
        m_cause  = kind[1:0];
      end else if (ret) begin
        m_kernel = 0;
      end
      if (kind == 1)         m_pend = 0;
      else if (irq && user)  m_pend = 1;
    end
    #1;
    check("kernel_mode", {31'd0, kernel_mode}, {31'd0, m_kernel});
`ifdef BREAK_CAUSE_EN
    check("break_cause", {30'd0, break_cause}, {30'd0, m_cause});
`endif
  endtask

  initial begin
    idle();
    // Reset with a would-be interrupt present: nothing may fire
    reset = 1; irq = 1; id_valid = 1; id_pc = 32'h40;
    apply(); apply();
    // Single-cycle irq pulse in USER
    idle(); irq = 1; id_valid = 1; id_pc = 32'h0000_0040; apply();
    idle(); id_valid = 1; id_pc = 32'h8000_0004; apply();
    // In KERNEL, irq and syscall are ignored
    idle(); irq = 1; id_valid = 1; id_syscall = 1; id_pc = 32'h8000_0008; apply();
    // eret at T, bubble at T+1 defers, take at T+2
    idle(); irq = 1; id_valid = 1; id_eret = 1; id_pc = 32'h8000_000C; apply();
    idle(); irq = 1; apply();
    idle(); irq = 1; id_valid = 1; id_pc = 32'h0000_0040; apply();
    idle(); id_valid = 1; id_eret = 1; apply();
    // Undef beats a simultaneous irq; irq stays pending through the handler
    idle(); irq = 1; id_valid = 1; id_undef = 1; id_syscall = 1; id_pc = 32'h0000_0100; apply();
    idle(); id_valid = 1; id_eret = 1; apply();
    idle(); id_valid = 1; id_pc = 32'h0000_0104; apply();
    idle(); id_valid = 1; id_eret = 1; apply();
    // Interrupt on a squashed slot returns to the branch target
    idle(); irq = 1; id_valid = 1; id_squash = 1; redirect_pc = 32'h0000_0200; id_pc = 32'h44; apply();
    idle(); id_valid = 1; id_eret = 1; apply();
    // Three stalled cycles, then take with the current id_pc
    for (int i = 0; i < 3; i++) begin
      idle(); irq = 1; id_valid = 1; pipe_stall = 1; id_pc = 32'h0000_0300; apply();
    end
    idle(); irq = 1; id_valid = 1; id_pc = 32'h0000_0300; apply();
    // Reset mid-handler
    idle(); reset = 1; id_valid = 1; id_eret = 1; apply();
    // Syscall at top of address space wraps the return PC
    idle(); id_valid = 1; id_syscall = 1; id_pc = 32'hFFFF_FFFC; apply();
    idle(); id_valid = 1; id_eret = 1; apply();
    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom % 50) == 0;
      irq         = ($urandom % 4) == 0;
      id_valid    = ($urandom % 4) != 0;
      id_squash   = ($urandom % 6) == 0;
      id_undef    = ($urandom % 8) == 0;
      id_syscall  = ($urandom % 8) == 0;
      id_eret     = ($urandom % 3) == 0;
      pipe_stall  = ($urandom % 5) == 0;
      id_pc       = $urandom & 32'hFFFF_FFFC;
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      apply();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
